// File: rtl/sni_bitap_matcher.sv
// Shift-and byte-pattern matcher with packet framing and sticky hit.
// Define SNI_WILDCARD_EN to enable the unbounded gap before pattern[WILD_POS].
module sni_bitap_matcher #(
  parameter int BPC      = 2,
  parameter int PAT_LEN  = 8,
  parameter int WILD_POS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_sop,
  input  logic                       i_eop,
  input  logic [$clog2(BPC+1)-1:0]   i_last_bytes,
  input  logic [8*BPC-1:0]           i_data,
  input  logic                       i_cfg_we,
  input  logic [7:0]                 i_cfg_addr,
  input  logic [PAT_LEN-1:0]         i_cfg_data,
  output logic                       o_match,
  output logic                       o_pkt_done,
  output logic                       o_pkt_hit
);

  typedef logic [PAT_LEN-1:0] st_t;

  typedef struct packed {
    logic                  vld;
    logic                  sop;
    logic                  eop;
    logic [BPC-1:0]        lv;
    logic [BPC-1:0][PAT_LEN-1:0] mask;
  } s1_t;

  if (BPC < 1 || BPC > 4) begin : g_bad_bpc
    $error("BPC out of range");
  end
  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("PAT_LEN out of range");
  end
  if (WILD_POS < 1 || WILD_POS >= PAT_LEN) begin : g_bad_wild
    $error("WILD_POS out of range");
  end

  logic [1:0] rst_q;
  logic       rst_n;

  st_t  tbl [256];
  s1_t  s1_d;
  s1_t  s1_q;

  st_t  d_q;
  logic stk_q;
  st_t  d_c;
  st_t  d_n;
  logic hit_c;
  logic stk_c;

  // Async assert, clock-aligned release of the internal reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_q <= '0;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  assign rst_n = rst_q[1];

  // Mask table: written by software, cleared only by reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        tbl[i] <= '0;
      end
    end else if (i_cfg_we) begin
      tbl[i_cfg_addr] <= i_cfg_data;
    end
  end

  // Per-lane mask lookup and lane-valid vector for stage 1.
  always_comb begin
    s1_d     = '0;
    s1_d.vld = i_valid;
    s1_d.sop = i_sop;
    s1_d.eop = i_eop;
    for (int l = 0; l < BPC; l++) begin
      s1_d.mask[l] = tbl[i_data[8*l +: 8]];
      s1_d.lv[l]   = !i_eop ||
                     ((l + int'(i_last_bytes)) >= BPC);
    end
  end

  // Stage 1 register; payload held across bubbles.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= i_valid;
      if (i_valid) begin
        s1_q.sop  <= s1_d.sop;
        s1_q.eop  <= s1_d.eop;
        s1_q.lv   <= s1_d.lv;
        s1_q.mask <= s1_d.mask;
      end
    end
  end

  // Shift-and update across lanes, high lane first.
  always_comb begin
    d_n   = '0;
    hit_c = 1'b0;
    stk_c = s1_q.sop ? 1'b0 : stk_q;
    d_c   = s1_q.sop ? '0 : d_q;
    for (int l = BPC - 1; l >= 0; l--) begin
      if (s1_q.lv[l]) begin
        d_n = {d_c[PAT_LEN-2:0], 1'b1} & s1_q.mask[l];
`ifdef SNI_WILDCARD_EN
        d_n[WILD_POS-1] = d_n[WILD_POS-1] | d_c[WILD_POS-1];
`endif
        d_c   = d_n;
        hit_c = hit_c | d_c[PAT_LEN-1];
      end
    end
  end

  // Stage 2: state, sticky hit and output pulses.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q        <= '0;
      stk_q      <= 1'b0;
      o_match    <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_hit  <= 1'b0;
    end else if (s1_q.vld) begin
      d_q        <= s1_q.eop ? '0 : d_c;
      stk_q      <= s1_q.eop ? 1'b0 : (stk_c | hit_c);
      o_match    <= hit_c;
      o_pkt_done <= s1_q.eop;
      o_pkt_hit  <= s1_q.eop & (stk_c | hit_c);
    end else begin
      o_match    <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sni_bitap_matcher.sv
// Scoreboard bench for sni_bitap_matcher (BPC=2, PAT_LEN=3, "ftp").
// Expected events are queued at drive time and popped by a monitor.
module tb_sni_bitap_matcher;

  localparam int BPC = 2;
  localparam int PL  = 3;

  localparam logic [7:0] F = 8'h66;
  localparam logic [7:0] T = 8'h74;
  localparam logic [7:0] P = 8'h70;
  localparam logic [7:0] X = 8'h78;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          sop;
  logic          eop;
  logic [1:0]    lb;
  logic [15:0]   data;
  logic          we;
  logic [7:0]    addr;
  logic [PL-1:0] wdata;
  logic          o_match;
  logic          o_pkt_done;
  logic          o_pkt_hit;

  typedef struct {
    bit m;
    bit d;
    bit h;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   wild;

  sni_bitap_matcher #(
    .BPC(BPC),
    .PAT_LEN(PL),
    .WILD_POS(1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .i_sop(sop),
    .i_eop(eop),
    .i_last_bytes(lb),
    .i_data(data),
    .i_cfg_we(we),
    .i_cfg_addr(addr),
    .i_cfg_data(wdata),
    .o_match(o_match),
    .o_pkt_done(o_pkt_done),
    .o_pkt_hit(o_pkt_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_match || o_pkt_done) begin
      exp_t e;
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_out cyc=%0d got m=%0b d=%0b h=%0b want none",
                 cyc, o_match, o_pkt_done, o_pkt_hit);
      end else begin
        e = q.pop_front();
        if (o_match !== e.m || o_pkt_done !== e.d ||
            o_pkt_hit !== e.h || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL event cyc=%0d got m=%0b d=%0b h=%0b want m=%0b d=%0b h=%0b at cyc=%0d",
                   cyc, o_match, o_pkt_done, o_pkt_hit, e.m, e.d, e.h, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] hi, input logic [7:0] lo,
                      input bit s, input bit e, input int nb,
                      input bit em, input bit ed, input bit eh);
    exp_t x;
    valid = 1'b1;
    sop   = s;
    eop   = e;
    lb    = 2'(nb);
    data  = {hi, lo};
    if (em || ed) begin
      x.m   = em;
      x.d   = ed;
      x.h   = eh;
      x.cyc = cyc + 2;
      q.push_back(x);
    end
    tick();
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [PL-1:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    compared++;
    if (o_match !== 1'b0 || o_pkt_done !== 1'b0 || o_pkt_hit !== 1'b0) begin
      mismatched++;
      $display("FAIL %s got m=%0b d=%0b h=%0b want 0 0 0",
               nm, o_match, o_pkt_done, o_pkt_hit);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef SNI_WILDCARD_EN
    wild = 1'b1;
`else
    wild = 1'b0;
`endif
    rst_n = 1'b0;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    lb    = 2'd0;
    data  = '0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) tick();
    chk_idle("reset_outputs");
    rst_n = 1'b1;
    repeat (4) tick();

    wr(F, 3'b001);
    wr(T, 3'b010);
    wr(P, 3'b100);
    tick();

    // x f | t p : match and hit on the eop beat
    beat(X, F, 1, 0, 2, 0, 0, 0);
    beat(T, P, 0, 1, 2, 1, 1, 1);
    repeat (3) tick();

    // sop clears carried state between single-beat packets
    beat(F, T, 1, 1, 2, 0, 1, 0);
    beat(P, X, 1, 1, 2, 0, 1, 0);
    repeat (3) tick();

    // partial last beat hides the p
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(X, P, 0, 1, 1, 0, 1, 0);
    repeat (3) tick();

    // partial last beat keeps the high-lane p
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(P, P, 0, 1, 1, 1, 1, 1);
    repeat (3) tick();

    // overlapping ftpftp with a bubble: two matches
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(P, F, 0, 0, 2, 1, 0, 0);
    tick();
    beat(T, P, 0, 1, 2, 1, 1, 1);
    repeat (3) tick();

    // open packet dropped by a new sop
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(X, F, 1, 0, 2, 0, 0, 0);
    beat(T, P, 0, 1, 2, 1, 1, 1);
    repeat (3) tick();

    // f xxxx tp with bubbles: only the wildcard build matches
    beat(F, X, 1, 0, 2, 0, 0, 0);
    tick();
    beat(X, X, 0, 0, 2, 0, 0, 0);
    beat(X, T, 0, 0, 2, 0, 0, 0);
    tick();
    beat(P, X, 0, 1, 1, wild, 1, wild);
    repeat (3) tick();

    // table write on the same edge as the lookup reads the old entry
    beat(X, F, 1, 0, 2, 0, 0, 0);
    we    = 1'b1;
    addr  = P;
    wdata = 3'b000;
    beat(T, P, 0, 1, 2, 1, 1, 1);
    we    = 1'b0;
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(P, X, 0, 1, 2, 0, 1, 0);
    repeat (3) tick();
    wr(P, 3'b100);
    tick();

    // reset mid-packet loses state and clears the table
    beat(X, F, 1, 0, 2, 0, 0, 0);
    rst_n = 1'b0;
    chk_idle("midreset_outputs_a");
    chk_idle("midreset_outputs_b");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    beat(T, P, 0, 1, 2, 0, 1, 0);
    repeat (3) tick();
    beat(F, T, 1, 0, 2, 0, 0, 0);
    beat(P, X, 0, 1, 2, 0, 1, 0);
    repeat (5) tick();

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event want m=%0b d=%0b h=%0b at cyc=%0d",
               e.m, e.d, e.h, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
